// File: rtl/aiken_pkg.sv
// Shared definitions for the Aiken digit packer: default width, FSM encoding,
// and the bounds of the Aiken-illegal code range.
package aiken_pkg;

  localparam int NDIG_DEF = 4;

  localparam logic [3:0] ILL_LO = 4'b0101;
  localparam logic [3:0] ILL_HI = 4'b1010;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/aiken_chk.sv
// Flags a 4-bit code that is not a legal Aiken (2-4-2-1) digit.
// Purely combinational.
module aiken_chk
  import aiken_pkg::*;
(
  input  logic [3:0] code,
  output logic       bad
);

  assign bad = (code >= ILL_LO) && (code <= ILL_HI);

endmodule

// File: rtl/aiken_pack.sv
// Packs NDIG Aiken digits (or fewer on in_last) into one word with an error flag.
// Latency 1 from the completing accept; in_ready drops only while a word is held and not taken.
module aiken_pack
  import aiken_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aiken,
  input  logic              in_invalid,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_word,
  output logic [3:0]        out_count,
  output logic              out_err
);

  state_t state;
  logic   code_bad;
  logic   bad;
  logic   accept;
  logic   done;

  aiken_chk u_chk (
    .code (in_aiken),
    .bad  (code_bad)
  );

  assign bad      = in_invalid | code_bad;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign done     = in_last || (out_count == 4'(NDIG - 1));

  // The out_* registers double as the accumulator, so the held word is inherently stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        EMPTY, FILL: begin
          if (accept) begin
            for (int k = 0; k < NDIG; k++) begin
              if (out_count == 4'(k)) out_word[4*k +: 4] <= in_aiken;
            end
            out_count <= out_count + 4'd1;
            out_err   <= out_err | bad;
            if (done) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end else begin
              state     <= FILL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) begin
              // Word leaves and the new digit becomes digit 0 in the same edge.
              out_word  <= {{(4*NDIG-4){1'b0}}, in_aiken};
              out_count <= 4'd1;
              out_err   <= bad;
              state     <= in_last ? FULL : FILL;
              out_valid <= in_last;
            end else begin
              out_word  <= '0;
              out_count <= '0;
              out_err   <= 1'b0;
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_word  <= '0;
          out_count <= '0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
